ifmap_row_framer: RTL and testbench

//  Upstream feeder of the conv datapath IF buffer. Takes raw signed ifmap samples from a

---
 rtl/ifmap_pkg.sv | 16 +
 rtl/ifmap_row_framer_tag_gen.sv | 26 ++
 rtl/ifmap_row_framer.sv | 102 ++++++++++
 tb/tb_ifmap_row_framer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_pkg.sv
// Shared definitions for the ifmap row framer and the IF-buffer consumer:
// row-position tags carried in the top two bits of each word, and FSM state codes.
package ifmap_pkg;

  typedef logic [1:0] tag_t;

  localparam tag_t TAG_START  = 2'b10;
  localparam tag_t TAG_END    = 2'b01;
  localparam tag_t TAG_MID    = 2'b00;
  localparam tag_t TAG_SINGLE = 2'b11;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

endpackage

// File: rtl/ifmap_row_framer_tag_gen.sv
// Row-position tag for the sample at column col of a row that is row_len_q samples long.
module tag_gen
  import ifmap_pkg::*;
#(
  parameter int LEN_WIDTH = 8
) (
  input  logic [LEN_WIDTH-1:0] col,
  input  logic [LEN_WIDTH-1:0] row_len_q,
  output tag_t                 tag
);

  logic first;
  logic last;

  assign first = (col == '0);
  assign last  = (col == row_len_q - LEN_WIDTH'(1));

  // NOTE: assign a default before any branch so no path leaves tag unassigned (no latch).
  always_comb begin
    tag = TAG_MID;
    if (first && last) tag = TAG_SINGLE;
    else if (first)    tag = TAG_START;
    else if (last)     tag = TAG_END;
  end

endmodule

// File: rtl/ifmap_row_framer.sv
// Frames a raw ifmap sample stream into tagged {tag, data} words for the IF buffer,
// with a one-deep output register that stalls cleanly on IF_full.
module ifmap_row_framer
  import ifmap_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int ROWS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [ROWS_WIDTH-1:0] num_rows,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH+1:0] IF_din,
  output logic                  IF_wen,
  input  logic                  IF_full,
  output logic                  busy,
  output logic                  done
);

  logic [1:0]            state;
  logic [LEN_WIDTH-1:0]  row_len_q;
  logic [ROWS_WIDTH-1:0] num_rows_q;
  logic [LEN_WIDTH-1:0]  col;
  logic [ROWS_WIDTH-1:0] row;
  logic                  out_valid;
  tag_t                  tag;
  logic                  accept;
  logic                  last_col;
  logic                  last_sample;

  tag_gen #(.LEN_WIDTH(LEN_WIDTH)) u_tag_gen (
    .col       (col),
    .row_len_q (row_len_q),
    .tag       (tag)
  );

  assign IF_wen      = out_valid && !IF_full;
  assign in_ready    = (state == STREAM) && (!out_valid || !IF_full);
  assign accept      = in_valid && in_ready;
  assign last_col    = (col == row_len_q - LEN_WIDTH'(1));
  assign last_sample = last_col && (row == num_rows_q - ROWS_WIDTH'(1));
  assign busy        = (state != IDLE);
  // FLUSH ends once the final word has left the output register (or there never was one).
  assign done        = (state == FLUSH) && (!out_valid || IF_wen);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      row_len_q  <= '0;
      num_rows_q <= '0;
      col        <= '0;
      row        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            row_len_q  <= row_len;
            num_rows_q <= num_rows;
            col        <= '0;
            row        <= '0;
            state      <= (row_len == '0 || num_rows == '0) ? FLUSH : STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            if (last_col) begin
              col <= '0;
              row <= row + ROWS_WIDTH'(1);
            end else begin
              col <= col + LEN_WIDTH'(1);
            end
            if (last_sample) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new word may enter in the same cycle the held one is written, giving one word per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      IF_din    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      IF_din    <= {tag, in_data};
    end else if (IF_wen) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifmap_row_framer.sv
// Randomised bench for ifmap_row_framer: an expected-word queue built from the row/column
// tagging rules plus a pending-word count predicts every write, stall, ready and done.
module tb_ifmap_row_framer;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] row_len;
  logic [RW-1:0] num_rows;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW+1:0] IF_din;
  logic          IF_wen;
  logic          IF_full;
  logic          busy;
  logic          done;

  ifmap_row_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ROWS_WIDTH(RW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .row_len  (row_len),
    .num_rows (num_rows),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .IF_din   (IF_din),
    .IF_wen   (IF_wen),
    .IF_full  (IF_full),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fix_q[$];
  logic [DW-1:0] samp[$];
  logic [DW+1:0] exp_q[$];
  int  idx, pend, done_seen;
  int  vprob = 100, fprob = 0, burst_at = -1, burst_len = 0, burst_left = 0;
  bit  streaming, frame_active, mid_start, mid_fired;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Called #1 after a rising edge: choose this cycle's inputs.
  task automatic drive();
    in_valid = streaming && (idx < samp.size()) && ($urandom_range(99) < vprob);
    in_data  = (idx < samp.size()) ? samp[idx] : '0;
    if (burst_left > 0) begin
      IF_full = 1'b1;
      burst_left--;
    end else begin
      IF_full = ($urandom_range(99) < fprob);
    end
    start = 1'b0;
    if (mid_start && !mid_fired && idx == 2) begin
      start     = 1'b1;
      row_len   = LW'(9);
      num_rows  = RW'(3);
      mid_fired = 1'b1;
    end
  endtask

  // Observe one cycle at the falling edge, then advance to #1 after the next rising edge.
  task automatic tick();
    logic [31:0] want;
    bit acc;
    bit exp_done;
    @(negedge clk);
    check("wen", IF_wen, (pend > 0) && !IF_full);
    check("ready", in_ready, streaming && (idx < samp.size()) && (pend == 0 || !IF_full));
    if (pend > 0 && IF_full) begin
      want = (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hFFFF_FFFF;
      check("hold", IF_din, want);
    end
    exp_done = 1'b0;
    if (IF_wen) begin
      want = 32'hFFFF_FFFF;
      if (exp_q.size() > 0) want = 32'(exp_q.pop_front());
      check("word", IF_din, want);
      exp_done = (exp_q.size() == 0);
      pend--;
    end
    if (frame_active) check("done", done, exp_done);
    if (done) done_seen++;
    acc = in_valid && in_ready;
    if (acc) pend++;
    @(posedge clk);
    #1;
    if (acc) begin
      idx++;
      if (idx == burst_at) burst_left = burst_len;
    end
  endtask

  task automatic begin_frame(input int len, input int rows, input bit use_fix);
    samp.delete();
    exp_q.delete();
    for (int k = 0; k < len * rows; k++)
      samp.push_back(use_fix ? fix_q[k] : DW'($urandom));
    for (int k = 0; k < len * rows; k++) begin
      int c;
      c = k % len;
      exp_q.push_back({(c == 0), (c == len - 1), samp[k]});
    end
    idx = 0; pend = 0; done_seen = 0; mid_fired = 0; burst_left = 0;
    frame_active = 1'b1;
    streaming    = 1'b0;
    start    = 1'b1;
    row_len  = LW'(len);
    num_rows = RW'(rows);
    in_valid = 1'b1;
    in_data  = samp[0];
    IF_full  = 1'b0;
    tick();
    start     = 1'b0;
    streaming = 1'b1;
  endtask

  task automatic finish_frame();
    int cyc;
    cyc = 0;
    while (done_seen == 0 && cyc < 3000) begin
      drive();
      tick();
      cyc++;
    end
    check("frame_done", done_seen, 1);
    check("words_left", exp_q.size(), 0);
    frame_active = 1'b0;
    streaming    = 1'b0;
    in_valid = 1'b0; IF_full = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_after", busy, 0);
    @(posedge clk);
    #1;
    vprob = 100; fprob = 0; burst_at = -1; burst_len = 0; mid_start = 0;
  endtask

  task automatic run_frame(input int len, input int rows, input bit use_fix);
    begin_frame(len, rows, use_fix);
    finish_frame();
  endtask

  // Empty frame; a second start lands in the done cycle and must be ignored.
  task automatic run_empty(input int len, input int rows);
    start = 1'b1; row_len = LW'(len); num_rows = RW'(rows);
    in_valid = 1'b1; in_data = 16'h1234; IF_full = 1'b0;
    @(negedge clk);
    check("empty_pre_busy", busy, 0);
    check("empty_pre_ready", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b1; row_len = LW'(2); num_rows = RW'(1);
    @(negedge clk);
    check("empty_busy", busy, 1);
    check("empty_done", done, 1);
    check("empty_wen", IF_wen, 0);
    check("empty_ready", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("empty_idle", busy, 0);
    check("empty_done_once", done, 0);
    @(negedge clk);
    check("empty_start_ignored", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; row_len = '0; num_rows = '0;
    in_valid = 1'b0; in_data = '0; IF_full = 1'b0;
    idx = 0; pend = 0; done_seen = 0;
    streaming = 0; frame_active = 0; mid_start = 0; mid_fired = 0;
    #12;
    check("rst_wen", IF_wen, 0);
    check("rst_din", IF_din, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    fix_q = '{16'd161, 16'd190, -16'sd161, -16'sd81, 16'd50};
    run_frame(5, 1, 1'b1);

    fix_q = '{16'd7, 16'd8, 16'd9};
    run_frame(1, 3, 1'b1);

    burst_at = 2; burst_len = 4;
    run_frame(3, 2, 1'b0);

    mid_start = 1'b1; vprob = 70;
    run_frame(4, 2, 1'b0);

    run_empty(5, 0);
    run_empty(0, 3);

    fix_q = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd55};
    begin_frame(5, 1, 1'b1);
    for (int c = 0; c < 100 && idx < 2; c++) begin
      drive();
      tick();
    end
    rst = 1'b0;
    #1;
    check("mid_rst_wen", IF_wen, 0);
    check("mid_rst_din", IF_din, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    frame_active = 1'b0; streaming = 1'b0; in_valid = 1'b0;
    exp_q.delete(); pend = 0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    run_frame(5, 1, 1'b1);

    for (int f = 0; f < 8; f++) begin
      vprob = 40 + $urandom_range(60);
      fprob = $urandom_range(50);
      run_frame(1 + $urandom_range(5), 1 + $urandom_range(3), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
